// File: rtl/alu_md_pipe_pkg.sv
// alu_md_pipe_pkg: opcodes and FSM states shared by the EX-stage ALU and its mul/div unit
package alu_md_pipe_pkg;
  localparam logic [4:0] OP_ADD   = 5'h01;
  localparam logic [4:0] OP_SUB   = 5'h02;
  localparam logic [4:0] OP_AND   = 5'h03;
  localparam logic [4:0] OP_OR    = 5'h04;
  localparam logic [4:0] OP_XOR   = 5'h05;
  localparam logic [4:0] OP_NOR   = 5'h06;
  localparam logic [4:0] OP_SLT   = 5'h07;
  localparam logic [4:0] OP_SLL   = 5'h08;
  localparam logic [4:0] OP_SRL   = 5'h09;
  localparam logic [4:0] OP_SRA   = 5'h0A;
  localparam logic [4:0] OP_SLTU  = 5'h0B;
  localparam logic [4:0] OP_MULT  = 5'h10;
  localparam logic [4:0] OP_MULTU = 5'h11;
  localparam logic [4:0] OP_DIV   = 5'h12;
  localparam logic [4:0] OP_DIVU  = 5'h13;
  localparam logic [4:0] OP_MFHI  = 5'h14;
  localparam logic [4:0] OP_MFLO  = 5'h15;
  localparam logic [4:0] OP_MTHI  = 5'h16;
  localparam logic [4:0] OP_MTLO  = 5'h17;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
endpackage

// File: rtl/alu_md_pipe_muldiv_seq.sv
// muldiv_seq: iterative shift-add multiplier / restoring divider on magnitudes, one bit per cycle.
// done marks the sign-fix cycle; hi_res/lo_res are valid from the following cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             done,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic act, div_q, neg_q, neg_r, dz, sa, sb, ge;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] m, acc, q, ma, mb, d;
  logic [WIDTH:0] sum, t;
  logic [2*WIDTH-1:0] pc;
  assign sa   = is_signed & a[WIDTH-1];
  assign sb   = is_signed & b[WIDTH-1];
  assign ma   = sa ? -a : a;
  assign mb   = sb ? -b : b;
  assign sum  = {1'b0, acc} + {1'b0, q[0] ? m : '0};
  assign t    = {acc, q[WIDTH-1]};
  assign ge   = t >= {1'b0, m};
  assign d    = t[WIDTH-1:0] - m;
  assign pc   = neg_q ? -{acc, q} : {acc, q};
  assign done = act && cnt == CW'(WIDTH);
  // acc/q double as product {hi,lo} for multiply and remainder/quotient for divide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {act, div_q, neg_q, neg_r, dz} <= '0;
      cnt    <= '0;
      m      <= '0;
      acc    <= '0;
      q      <= '0;
      hi_res <= '0;
      lo_res <= '0;
    end else if (flush) begin
      act <= 1'b0;
    end else if (start) begin
      act   <= 1'b1;
      cnt   <= '0;
      acc   <= '0;
      m     <= is_div ? mb : ma;
      q     <= is_div ? ma : mb;
      div_q <= is_div;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      dz    <= b == '0;
    end else if (done) begin
      act    <= 1'b0;
      hi_res <= div_q ? (neg_r ? -acc : acc) : pc[2*WIDTH-1:WIDTH];
      lo_res <= div_q ? (dz ? '1 : (neg_q ? -q : q)) : pc[WIDTH-1:0];
    end else if (act) begin
      cnt <= cnt + 1'b1;
      acc <= div_q ? (ge ? d : t[WIDTH-1:0]) : sum[WIDTH:1];
      q   <= div_q ? {q[WIDTH-2:0], ge} : {sum[0], q[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/alu_md_pipe.sv
// alu_md_pipe: registered EX-stage ALU with valid/ready handshake, iterative mul/div and HI/LO.
module alu_md_pipe import alu_md_pipe_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         op,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  input  logic [WIDTH-1:0]   imm,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               alu_source,
  input  logic               alu_source_shift,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   alu_out,
  output logic               zero,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  state_t state, state_n;
  logic [WIDTH-1:0] opr_a, opr_b, res, hi_res, lo_res;
  logic [SHAMT_W-1:0] sh;
  logic accept, is_md, md_done, fix_commit;
  assign in_ready   = state == S_IDLE && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready && !flush;
  assign is_md      = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign busy       = state != S_IDLE;
  assign fix_commit = state == S_FIX && !flush;
  assign opr_a      = alu_source_shift ? {{(WIDTH-SHAMT_W){1'b0}}, shamt} : rs;
  assign opr_b      = alu_source ? imm : rt;
  assign sh         = opr_a[SHAMT_W-1:0];
  // MT*, mul/div and undefined opcodes all fall to a zero result
  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = opr_a + opr_b;
      OP_SUB:  res = opr_a - opr_b;
      OP_AND:  res = opr_a & opr_b;
      OP_OR:   res = opr_a | opr_b;
      OP_XOR:  res = opr_a ^ opr_b;
      OP_NOR:  res = ~(opr_a | opr_b);
      OP_SLT:  res = WIDTH'($signed(opr_a) < $signed(opr_b));
      OP_SLTU: res = WIDTH'(opr_a < opr_b);
      OP_SLL:  res = opr_b << sh;
      OP_SRL:  res = opr_b >> sh;
      OP_SRA:  res = $signed(opr_b) >>> sh;
      OP_MFHI: res = hi;
      OP_MFLO: res = lo;
      default: res = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = accept && is_md ? S_CALC : S_IDLE;
      S_CALC:  state_n = flush ? S_IDLE : md_done ? S_FIX : S_CALC;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      zero      <= 1'b1;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= flush ? 1'b0 : (accept && !is_md) ? 1'b1 : out_ready ? 1'b0 : out_valid;
      alu_out   <= (accept && !is_md) ? res : alu_out;
      zero      <= (accept && !is_md) ? res == '0 : zero;
      hi        <= fix_commit ? hi_res : (accept && op == OP_MTHI) ? rs : hi;
      lo        <= fix_commit ? lo_res : (accept && op == OP_MTLO) ? rs : lo;
    end
  end
  muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept && is_md),
    .is_div   (op == OP_DIV || op == OP_DIVU),
    .is_signed(op == OP_MULT || op == OP_DIV),
    .a        (opr_a),
    .b        (opr_b),
    .flush    (flush),
    .done     (md_done),
    .hi_res   (hi_res),
    .lo_res   (lo_res)
  );
endmodule
